// File: rtl/fifo_rd_packer.sv
// Read-side packer behind an async FIFO: pops show-ahead entries and packs WORDS of them
// into one wide valid/ready beat, with flush and idle-timeout emission of partial words.
module fifo_rd_packer #(
    parameter int DSIZE   = 8,
    parameter int WORDS   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*WORDS-1:0] out_data,
    output logic [WORDS-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int NW = CW + 1;
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST    = CW'(WORDS - 1);
    localparam logic [IW-1:0] TMO_VAL = IW'(TIMEOUT);

    typedef enum logic {EMPTY, FILL} state_t;

    state_t                      state, state_next;
    logic [CW-1:0]               cnt, cnt_next;
    logic [WORDS-1:0][DSIZE-1:0] acc, acc_next;
    logic                        flush_pend, flush_pend_next;
    logic [IW-1:0]               idle, idle_next;
    logic [DSIZE*WORDS-1:0]      data_next, word;
    logic [WORDS-1:0]            keep_next, word_keep;
    logic                        valid_next;
    logic                        out_free, pop, emit, tmo;
    logic [NW-1:0]               n_emit;

    assign rinc = pop;

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        acc_next        = acc;
        flush_pend_next = flush_pend;
        idle_next       = idle;
        data_next       = out_data;
        keep_next       = out_keep;
        valid_next      = out_valid;
        word            = '0;
        word_keep       = '0;

        out_free = !out_valid || out_ready;
        tmo      = (TIMEOUT != 0) && (idle == TMO_VAL);
        // Pops may keep filling a partial word under backpressure, but never the completing entry.
        pop      = !rrst && !rempty &&
                   (out_free || (cnt != LAST && !flush_pend && !tmo));
        emit     = !rrst && out_free &&
                   ((pop && cnt == LAST) ||
                    ((flush_pend || flush || tmo) && (cnt != '0 || pop)));
        n_emit   = NW'(cnt) + NW'(pop);

        for (int i = 0; i < WORDS; i++) begin
            if (NW'(i) < NW'(cnt))
                word[i*DSIZE +: DSIZE] = acc[i];
            else if (pop && NW'(i) == NW'(cnt))
                word[i*DSIZE +: DSIZE] = rdata;
            word_keep[i] = NW'(i) < n_emit;
        end

        if (emit) begin
            data_next  = word;
            keep_next  = word_keep;
            valid_next = 1'b1;
            cnt_next   = '0;
            state_next = EMPTY;
        end else begin
            if (out_valid && out_ready)
                valid_next = 1'b0;
            if (pop) begin
                acc_next[cnt] = rdata;
                cnt_next      = cnt + CW'(1);
                state_next    = FILL;
            end
        end

        // A flush seen with nothing accumulated and nothing arriving is dropped.
        if (emit)
            flush_pend_next = 1'b0;
        else if (cnt == '0 && !pop)
            flush_pend_next = 1'b0;
        else if (flush)
            flush_pend_next = 1'b1;

        if (emit || pop)
            idle_next = '0;
        else if (state == FILL && idle != TMO_VAL)
            idle_next = idle + IW'(1);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state      <= EMPTY;
            cnt        <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
            idle       <= '0;
            out_data   <= '0;
            out_keep   <= '0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            acc        <= acc_next;
            flush_pend <= flush_pend_next;
            idle       <= idle_next;
            out_data   <= data_next;
            out_keep   <= keep_next;
            out_valid  <= valid_next;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: queue-based FIFO and packing model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_fifo_rd_packer;

    localparam int DSIZE   = 8;
    localparam int WORDS   = 4;
    localparam int TIMEOUT = 16;

    logic                   rclk = 1'b0;
    logic                   rrst;
    logic [DSIZE-1:0]       rdata;
    logic                   rempty;
    logic                   rinc;
    logic                   flush;
    logic [DSIZE*WORDS-1:0] out_data;
    logic [WORDS-1:0]       out_keep;
    logic                   out_valid;
    logic                   out_ready;

    fifo_rd_packer #(.DSIZE(DSIZE), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .flush(flush), .out_data(out_data), .out_keep(out_keep),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 rclk = ~rclk;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  check_en = 0;
    int  pop_count = 0;
    int  pop_cyc = 0;

    logic [DSIZE-1:0]  fifo_q[$];
    logic [35:0]       beats[$];
    int                beat_cyc[$];

    // Behavioural model: accumulator as a list of entries, output as a held beat.
    logic [DSIZE-1:0]       m_acc[$];
    bit                     m_valid = 0;
    logic [DSIZE*WORDS-1:0] m_data = '0;
    logic [WORDS-1:0]       m_keep = '0;
    bit                     m_fp = 0;
    int                     m_idle = 0;
    bit                     mp, mfree, mtmo, mem, dut_pop;
    int                     mn;
    logic [DSIZE*WORDS-1:0] md;

    function automatic void refresh_fifo();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endfunction

    function automatic bit exp_pop();
        bit free, tm;
        free = !m_valid || out_ready;
        tm   = (TIMEOUT != 0) && (m_idle == TIMEOUT);
        return !rrst && !rempty &&
               (free || (m_acc.size() < WORDS - 1 && !m_fp && !tm));
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial forever begin
        @(posedge rclk);
        cyc++;
        mp = exp_pop();
        if (rrst) begin
            m_acc.delete();
            m_valid = 0;
            m_data  = '0;
            m_keep  = '0;
            m_fp    = 0;
            m_idle  = 0;
        end else begin
            mn    = m_acc.size();
            mfree = !m_valid || out_ready;
            mtmo  = (TIMEOUT != 0) && (m_idle == TIMEOUT);
            mem   = mfree && ((mp && mn == WORDS - 1) ||
                              ((m_fp || flush || mtmo) && (mn > 0 || mp)));
            if (mp)
                m_acc.push_back(rdata);
            if (mem) begin
                md = '0;
                for (int k = 0; k < m_acc.size(); k++)
                    md[k*DSIZE +: DSIZE] = m_acc[k];
                m_data  = md;
                m_keep  = WORDS'((1 << m_acc.size()) - 1);
                m_valid = 1;
                m_acc.delete();
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (mem)
                m_fp = 0;
            else if (mn == 0 && !mp)
                m_fp = 0;
            else if (flush)
                m_fp = 1;
            if (mem || mp)
                m_idle = 0;
            else if (mn > 0 && m_idle < TIMEOUT)
                m_idle++;
        end
        dut_pop = rinc;
        if (out_valid && out_ready) begin
            beats.push_back({out_keep, out_data});
            beat_cyc.push_back(cyc);
        end
        if (rinc) begin
            pop_count++;
            pop_cyc = cyc;
        end
        #1;
        if (dut_pop && fifo_q.size() > 0)
            void'(fifo_q.pop_front());
        refresh_fifo();
    end

    always @(negedge rclk) begin
        if (check_en) begin
            check_output("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check_output("out_data", out_data, m_data);
                check_output("out_keep", out_keep, m_keep);
            end
            check_output("rinc", rinc, exp_pop());
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge rclk);
            #2;
        end
    endtask

    task automatic apply_stimulus(input logic [DSIZE-1:0] v);
        fifo_q.push_back(v);
        refresh_fifo();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int b = 0;
        while (beats.size() < n && b < budget) begin
            tick();
            b++;
        end
        if (beats.size() < n)
            check_output("beat_timeout", beats.size(), n);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int b;
        rrst      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        refresh_fifo();
        tick(2);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_out_keep", out_keep, 0);
        check_output("reset_out_data", out_data, 0);
        rrst     = 1'b0;
        check_en = 1;

        // Full word at full rate
        pop_count = 0;
        apply_stimulus(8'h11); apply_stimulus(8'h22);
        apply_stimulus(8'h33); apply_stimulus(8'h44);
        wait_beats(1, 10);
        check_output("full_word", beats[0], {4'hF, 32'h44332211});
        check_output("full_word_pops", pop_count, 4);
        check_output("full_word_accept_cycle", beat_cyc[0] - pop_cyc, 1);

        // Flush of a partial word, then a flush with nothing accumulated
        apply_stimulus(8'h01); apply_stimulus(8'h02);
        tick(3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_beats(2, 5);
        check_output("flush_word", beats[1], {4'h3, 32'h00000201});
        tick(2);
        base  = beats.size();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(4);
        check_output("empty_flush_beats", beats.size(), base);
        check_output("empty_flush_valid", out_valid, 0);

        // Idle timeout on a single entry: idle reaches TIMEOUT at pop+16, emission on the next edge
        apply_stimulus(8'hAB);
        tick();
        b = 0;
        while (!out_valid && b < 40) begin
            tick();
            b++;
        end
        check_output("tmo_latency", cyc - pop_cyc, TIMEOUT + 1);
        wait_beats(3, 5);
        check_output("tmo_word", beats[2], {4'h1, 32'h000000AB});

        // Backpressure: first word held, next three lanes fill, completing pop waits
        out_ready = 1'b0;
        pop_count = 0;
        base      = beats.size();
        for (int v = 8'h10; v <= 8'h17; v++)
            apply_stimulus(DSIZE'(v));
        tick(10);
        check_output("bp_rinc", rinc, 0);
        check_output("bp_pops", pop_count, 7);
        check_output("bp_held_data", out_data, 32'h13121110);
        check_output("bp_held_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_beats(base + 2, 6);
        check_output("bp_word0", beats[base], {4'hF, 32'h13121110});
        check_output("bp_word1", beats[base+1], {4'hF, 32'h17161514});
        check_output("bp_no_gap", beat_cyc[base+1] - beat_cyc[base], 1);
        check_output("bp_total_pops", pop_count, 8);

        // Reset mid-operation with a held beat and two lanes accumulated
        out_ready = 1'b0;
        base      = beats.size();
        apply_stimulus(8'h21); apply_stimulus(8'h22);
        apply_stimulus(8'h23); apply_stimulus(8'h24);
        tick(6);
        apply_stimulus(8'h25); apply_stimulus(8'h26);
        tick(4);
        check_output("pre_reset_valid", out_valid, 1);
        apply_stimulus(8'h27);
        rrst = 1'b1;
        #1;
        check_output("reset_rinc", rinc, 0);
        tick();
        rrst = 1'b0;
        check_output("post_reset_valid", out_valid, 0);
        check_output("post_reset_keep", out_keep, 0);
        out_ready = 1'b1;
        apply_stimulus(8'h28); apply_stimulus(8'h29); apply_stimulus(8'h2A);
        wait_beats(base + 1, 10);
        check_output("post_reset_word", beats[base], {4'hF, 32'h2A292827});
        tick(3);
        check_output("post_reset_beats", beats.size(), base + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
